ternary_stream_driver: RTL
==========================

// Module: ternary_stream_driver
// PURPOSE
// - Transmit side of the ternary MAC neuron stream interface: buffers one activation/weight vector,
//   then drives clear_acc, valid, weight[1:0] and activation[7:0] into the neuron.
// - Captures the neuron's saturated 8-bit result after the last beat.
// - Sits between the host/test controller and the neuron's ui_in/uio_in pins.
// PARAMETERS
// - N_MAX   16  vector buffer depth (max beats per run)
// - IDX_W    4  index width, clog2(N_MAX); vec_len is IDX_W+1 bits wide
// PORTS
// - clk         in    1        clock
// - rst_n       in    1        reset, synchronous, active-low
// - wr_en       in    1        buffer write strobe (accepted only when busy=0)
// - wr_addr     in    IDX_W    buffer entry index
// - wr_act      in    8        signed activation to store
// - wr_wt       in    2        ternary weight code: 01=+1, 10=-1, 00/11=0
// - start       in    1        begin run (accepted only when busy=0)
// - vec_len     in    IDX_W+1  beats in the run, 0..N_MAX; sampled with start
// - act_out     out   8        activation to neuron
// - wt_out      out   2        weight code to neuron
// - valid_out   out   1        beat strobe to neuron
// - clear_out   out   1        accumulator clear to neuron
// - result_in   in    8        neuron saturated output
// - result      out   8        captured result, held until next capture
// - busy        out   1        high from the cycle after start until done
// - done        out   1        one-cycle pulse when result is updated
// BEHAVIOUR
// - Reset (rst_n=0 at posedge): state=IDLE; act_out, wt_out, valid_out, clear_out, result, busy, done
//   all 0. Buffer contents are not reset. Reset mid-run aborts immediately; no done pulse.
// - All outputs are registered. FSM: IDLE -> CLEAR -> STREAM -> WAIT -> DONE -> IDLE.
// - IDLE: start=1 latches vec_len (values > N_MAX clamp to N_MAX) and enters CLEAR on the next cycle.
// - CLEAR (1 cycle): clear_out=1, valid_out=0, busy=1.
//   Next state: STREAM if len>0, otherwise WAIT.
// - STREAM (len cycles): beat i, i=0..len-1, drives act_out=buf_act[i] and valid_out=1.
//   wt_out=buf_wt[i], except code 11 is driven as 00. Index wraps to 0 on exit. Enters WAIT after beat len-1.
// - WAIT (1 cycle): valid_out=0, act_out=0, wt_out=0.
//   The neuron accumulator updated on the edge ending the last beat, so result_in is valid now.
//   result<=result_in at the end of WAIT.
// - DONE (1 cycle): done=1, busy=0. Returns to IDLE.
// - Latency: start sampled at edge t; done is high in cycle t+len+3.
// - start while busy is ignored. start coinciding with done (DONE state) is ignored.
// - wr_en while busy is ignored. Write and start in the same IDLE cycle: the write lands first,
//   and the run uses the new entry.
// - Entries at index >= len are never driven.
// CONFIGURATION
// - SKIP_ZERO_EN defined: in STREAM, a beat whose weight is 00 or 11 drives valid_out=0, act_out=0
//   and wt_out=00. Cycle count is unchanged; the change saves neuron/pad toggling.
// - SKIP_ZERO_EN undefined: every beat drives valid_out=1; zero weights rely on the neuron's hold.
// - Captured result is identical in both builds.
// TESTING
// - Write act={10,20,30}, wt={01,01,10}, start len=3 -> clear_out 1 cycle, 3 valid beats, result=0,
//   done at t+6. (10+20-30=0.)
// - act={100,100}, wt={01,01}, len=2 -> result=8'h7F (neuron saturation).
//   act={-100,-100}, wt={01,01} -> result=8'h80.
// - len=0 -> CLEAR then WAIT, no valid beats, result=0, done at t+3.
// - act={5,7}, wt={11,00}, len=2 -> wt_out=00 on both beats, result=0.
//   valid_out=1 on both beats without the macro, 0 with SKIP_ZERO_EN.
// - start and wr_en asserted mid-STREAM -> ignored: buffer unchanged, run completes with the original len.
// - rst_n=0 during STREAM beat 2 -> next cycle all outputs 0, IDLE, no done.
//   A new start then runs correctly from index 0.

Source files
------------

// File: rtl/ternary_stream_driver.sv
// Ternary MAC neuron stream driver: buffers a vector, streams it, captures the result.
// Build option: SKIP_ZERO_EN suppresses valid_out on zero-weight beats.
module ternary_stream_driver #(
  parameter int N_MAX = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [7:0]       wr_act,
  input  logic [1:0]       wr_wt,
  input  logic             start,
  input  logic [IDX_W:0]   vec_len,
  output logic [7:0]       act_out,
  output logic [1:0]       wt_out,
  output logic             valid_out,
  output logic             clear_out,
  input  logic [7:0]       result_in,
  output logic [7:0]       result,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [IDX_W:0] LP_MAX = (IDX_W+1)'(N_MAX);

  logic [7:0]       r_act_mem [N_MAX];
  logic [1:0]       r_wt_mem  [N_MAX];
  logic [2:0]       r_state;
  logic [IDX_W:0]   r_len;
  logic [IDX_W:0]   r_idx;
  logic [7:0]       r_act;
  logic [1:0]       r_wt;
  logic             r_valid;
  logic             r_clear;
  logic [7:0]       r_result;
  logic             r_busy;
  logic             r_done;

  logic [IDX_W-1:0] w_ridx;
  logic [7:0]       w_act;
  logic [1:0]       w_code;
  logic             w_zero;
  logic [7:0]       w_bact;
  logic [1:0]       w_bwt;
  logic             w_bvalid;
  logic [IDX_W:0]   w_len_c;

  // Buffer is deliberately not reset; writes land whenever no run is active.
  always_ff @(posedge clk) begin
    if (wr_en && !r_busy) begin
      r_act_mem[wr_addr] <= wr_act;
      r_wt_mem[wr_addr]  <= wr_wt;
    end
  end

  assign w_ridx  = r_idx[IDX_W-1:0];
  assign w_act   = r_act_mem[w_ridx];
  assign w_code  = r_wt_mem[w_ridx];
  assign w_zero  = (w_code == 2'b00) || (w_code == 2'b11);
  assign w_bwt   = w_zero ? 2'b00 : w_code;
  assign w_len_c = (vec_len > LP_MAX) ? LP_MAX : vec_len;

`ifdef SKIP_ZERO_EN
  assign w_bvalid = !w_zero;
  assign w_bact   = w_zero ? 8'd0 : w_act;
`else
  assign w_bvalid = 1'b1;
  assign w_bact   = w_act;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_len    <= '0;
      r_idx    <= '0;
      r_act    <= '0;
      r_wt     <= '0;
      r_valid  <= 1'b0;
      r_clear  <= 1'b0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len   <= w_len_c;
            r_idx   <= '0;
            r_clear <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_clear <= 1'b0;
          if (r_len != '0) begin
            r_act   <= w_bact;
            r_wt    <= w_bwt;
            r_valid <= w_bvalid;
            r_idx   <= r_idx + 1'b1;
            r_state <= S_STREAM;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_STREAM: begin
          if (r_idx == r_len) begin
            r_act   <= '0;
            r_wt    <= '0;
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_state <= S_WAIT;
          end else begin
            r_act   <= w_bact;
            r_wt    <= w_bwt;
            r_valid <= w_bvalid;
            r_idx   <= r_idx + 1'b1;
          end
        end
        S_WAIT: begin
          r_result <= result_in;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign act_out   = r_act;
  assign wt_out    = r_wt;
  assign valid_out = r_valid;
  assign clear_out = r_clear;
  assign result    = r_result;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
